// File: rtl/ofm_pack_wbuf.sv
// ---------------------------------------------------------------------------
// ofm_pack_wbuf
//   Output-feature-map packer and write buffer in front of dma_write.
//   Each signed 32-bit accumulator is requantised to int8 (arithmetic shift,
//   optional ReLU, saturation). Four results are packed little-endian into a
//   32-bit word. A whole tile is buffered before dma_write is launched, and
//   words are then served first-word-fall-through on dma_indata.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   cfg_start                 one-cycle pulse: latch cfg_* and start a tile
//   cfg_num_words             packed words in the tile (0 = empty tile)
//   cfg_base_addr             DRAM byte address of the tile
//   cfg_shift                 requantisation right-shift amount
//   in_valid/in_ready/in_data accumulator input handshake
//   dma_start_o               one-cycle launch pulse to dma_write
//   dma_num_trans             tile length to dma_write
//   dma_start_addr            tile address to dma_write
//   dma_indata                buffer head word (0 when empty or not draining)
//   dma_indata_req            pop request from dma_write
//   dma_done                  completion from dma_write
//   busy                      any state other than IDLE
//   done_o                    one-cycle pulse when the tile is finished
//   cfg_err                   one-cycle pulse on cfg_num_words > DEPTH
//   underflow_err             sticky: pop requested with the buffer empty
// ---------------------------------------------------------------------------
module ofm_pack_wbuf #(
  parameter int OUT_BITS_TRANS = 13,
  parameter int AXI_WIDTH_DA   = 32,
  parameter int DEPTH          = 1024,
  parameter bit RELU_EN        = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cfg_start,
  input  logic [OUT_BITS_TRANS-1:0] cfg_num_words,
  input  logic [AXI_WIDTH_DA-1:0]   cfg_base_addr,
  input  logic [4:0]                cfg_shift,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_data,
  output logic                      dma_start_o,
  output logic [OUT_BITS_TRANS-1:0] dma_num_trans,
  output logic [AXI_WIDTH_DA-1:0]   dma_start_addr,
  output logic [AXI_WIDTH_DA-1:0]   dma_indata,
  input  logic                      dma_indata_req,
  input  logic                      dma_done,
  output logic                      busy,
  output logic                      done_o,
  output logic                      cfg_err,
  output logic                      underflow_err
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit keeps full (DEPTH words) distinct from empty.
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, FILL, LAUNCH, DRAIN} state_e;

  state_e                    state_q, state_d;
  logic [OUT_BITS_TRANS-1:0] num_words_q, num_words_d;
  logic [AXI_WIDTH_DA-1:0]   base_addr_q, base_addr_d;
  logic [4:0]                shift_q, shift_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [1:0]                lane_q, lane_d;
  logic [23:0]               pack_q, pack_d;   // lanes 0..2; lane 3 goes straight to memory
  logic                      start_q, start_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      uf_q, uf_d;

  logic [AXI_WIDTH_DA-1:0]   mem [DEPTH];
  logic                      mem_we;
  logic [AXI_WIDTH_DA-1:0]   mem_wdata;

  logic signed [31:0]        shifted;
  logic [7:0]                q8;
  logic                      accept;
  logic                      empty;

  // -------------------------------------------------------------------------
  // Requantisation of the current input, using the shift latched for the tile
  // -------------------------------------------------------------------------
  always_comb begin
    shifted = $signed(in_data) >>> shift_q;
    if (RELU_EN && (shifted < 0)) shifted = '0;
    if (shifted > 127)       q8 = 8'h7F;
    else if (shifted < -128) q8 = 8'h80;
    else                     q8 = shifted[7:0];
  end

  assign empty     = (rd_ptr_q == wr_ptr_q);
  assign in_ready  = (state_q == FILL) && (32'(wr_ptr_q) < 32'(num_words_q));
  assign accept    = in_valid && in_ready;
  assign mem_wdata = {q8, pack_q};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    num_words_d = num_words_q;
    base_addr_d = base_addr_q;
    shift_d     = shift_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    uf_d        = uf_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_num_words == '0) begin
            done_d = 1'b1;
          end else if (32'(cfg_num_words) > 32'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            num_words_d = cfg_num_words;
            base_addr_d = cfg_base_addr;
            shift_d     = cfg_shift;
            uf_d        = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            lane_d      = '0;
            pack_d      = '0;
            state_d     = FILL;
          end
        end
      end

      FILL: begin
        if (accept) begin
          if (lane_q == 2'd3) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            lane_d   = '0;
            pack_d   = '0;
            if (32'(wr_ptr_d) == 32'(num_words_q)) begin
              state_d = LAUNCH;
              start_d = 1'b1;
            end
          end else begin
            lane_d = lane_q + 1'b1;
            case (lane_q)
              2'd0:    pack_d[7:0]   = q8;
              2'd1:    pack_d[15:8]  = q8;
              default: pack_d[23:16] = q8;
            endcase
          end
        end
      end

      LAUNCH: state_d = DRAIN;

      DRAIN: begin
        // Popping an empty buffer is flagged, not recovered: dma_write burst
        // retries cannot be re-supplied because popped words are gone.
        if (dma_indata_req) begin
          if (empty) uf_d     = 1'b1;
          else       rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (dma_done) begin
          done_d   = 1'b1;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rstn) begin
      state_q     <= IDLE;
      num_words_q <= '0;
      base_addr_q <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_words_q <= num_words_d;
      base_addr_q <= base_addr_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      uf_q        <= uf_d;
    end
  end

  // NOTE: the buffer array has no reset; the pointers define which entries
  // are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= mem_wdata;
  end

  assign busy           = (state_q != IDLE);
  assign dma_start_o    = start_q;
  assign done_o         = done_q;
  assign cfg_err        = err_q;
  assign underflow_err  = uf_q;
  assign dma_num_trans  = busy ? num_words_q : '0;
  assign dma_start_addr = busy ? base_addr_q : '0;
  assign dma_indata     = ((state_q == DRAIN) && !empty) ? mem[rd_ptr_q[AW-1:0]] : '0;

endmodule

// File: tb/tb_ofm_pack_wbuf.sv
// ---------------------------------------------------------------------------
// tb_ofm_pack_wbuf
//   Two instances share one stimulus stream: one with ReLU, one without.
//   A tile-level behavioural model predicts every output each cycle, and a
//   few literal expectations pin the model's arithmetic.
// ---------------------------------------------------------------------------
module tb_ofm_pack_wbuf;

  localparam int OBT   = 13;
  localparam int DEPTH = 1024;

  logic            clk = 1'b0;
  logic            rstn;
  logic            cfg_start;
  logic [OBT-1:0]  cfg_num_words;
  logic [31:0]     cfg_base_addr;
  logic [4:0]      cfg_shift;
  logic            in_valid;
  logic [31:0]     in_data;
  logic            dma_indata_req;
  logic            dma_done;

  logic            r_in_ready, r_start, r_busy, r_done, r_err, r_uf;
  logic [OBT-1:0]  r_num_trans;
  logic [31:0]     r_addr, r_indata;
  logic            n_in_ready, n_start, n_busy, n_done, n_err, n_uf;
  logic [OBT-1:0]  n_num_trans;
  logic [31:0]     n_addr, n_indata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ofm_pack_wbuf #(.OUT_BITS_TRANS(OBT), .AXI_WIDTH_DA(32), .DEPTH(DEPTH), .RELU_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_num_words(cfg_num_words),
    .cfg_base_addr(cfg_base_addr), .cfg_shift(cfg_shift), .in_valid(in_valid),
    .in_ready(r_in_ready), .in_data(in_data), .dma_start_o(r_start),
    .dma_num_trans(r_num_trans), .dma_start_addr(r_addr), .dma_indata(r_indata),
    .dma_indata_req(dma_indata_req), .dma_done(dma_done), .busy(r_busy),
    .done_o(r_done), .cfg_err(r_err), .underflow_err(r_uf));

  ofm_pack_wbuf #(.OUT_BITS_TRANS(OBT), .AXI_WIDTH_DA(32), .DEPTH(DEPTH), .RELU_EN(1'b0)) dut_nr (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_num_words(cfg_num_words),
    .cfg_base_addr(cfg_base_addr), .cfg_shift(cfg_shift), .in_valid(in_valid),
    .in_ready(n_in_ready), .in_data(in_data), .dma_start_o(n_start),
    .dma_num_trans(n_num_trans), .dma_start_addr(n_addr), .dma_indata(n_indata),
    .dma_indata_req(dma_indata_req), .dma_done(dma_done), .busy(n_busy),
    .done_o(n_done), .cfg_err(n_err), .underflow_err(n_uf));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s at %0t: timed out waiting for the design", name, $time);
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: a tile is a list of elements; the buffer is an array
  // of packed words plus a count of words handed out so far.
  // -------------------------------------------------------------------------
  function automatic logic [7:0] requant(input logic [31:0] x, input int sh, input bit relu);
    longint v = longint'($signed(x));
    longint d = longint'(1) << sh;
    longint s;
    if (v >= 0) s = v / d;
    else        s = -((-v + d - 1) / d);   // floor division for negatives
    if (relu && s < 0) s = 0;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  typedef enum int {M_IDLE, M_FILL, M_LAUNCH, M_DRAIN} phase_e;
  phase_e      m_phase;
  int unsigned m_nw, m_acc, m_rd;
  logic [31:0] m_base;
  int          m_shift;
  logic [31:0] m_cur_r, m_cur_n;
  logic [31:0] m_mem_r [DEPTH];
  logic [31:0] m_mem_n [DEPTH];
  bit          m_start, m_done, m_err, m_uf;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase = M_IDLE; m_nw = 0; m_acc = 0; m_rd = 0; m_base = '0; m_shift = 0;
      m_cur_r = '0; m_cur_n = '0; m_start = 0; m_done = 0; m_err = 0; m_uf = 0;
    end else begin
      m_start = 0; m_done = 0; m_err = 0;
      case (m_phase)
        M_IDLE: if (cfg_start) begin
          if (cfg_num_words == 0) m_done = 1;
          else if (int'(cfg_num_words) > DEPTH) m_err = 1;
          else begin
            m_nw = cfg_num_words; m_base = cfg_base_addr; m_shift = cfg_shift;
            m_uf = 0; m_acc = 0; m_rd = 0; m_cur_r = '0; m_cur_n = '0;
            m_phase = M_FILL;
          end
        end
        M_FILL: if (in_valid) begin
          m_cur_r |= 32'(requant(in_data, m_shift, 1'b1)) << (8 * (m_acc % 4));
          m_cur_n |= 32'(requant(in_data, m_shift, 1'b0)) << (8 * (m_acc % 4));
          if (m_acc % 4 == 3) begin
            m_mem_r[m_acc / 4] = m_cur_r; m_mem_n[m_acc / 4] = m_cur_n;
            m_cur_r = '0; m_cur_n = '0;
          end
          m_acc++;
          if (m_acc == 4 * m_nw) begin m_phase = M_LAUNCH; m_start = 1; end
        end
        M_LAUNCH: m_phase = M_DRAIN;
        M_DRAIN: begin
          if (dma_indata_req) begin
            if (m_rd < m_acc / 4) m_rd++;
            else                  m_uf = 1;
          end
          if (dma_done) begin m_done = 1; m_phase = M_IDLE; end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // One compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    logic        e_busy;
    logic [31:0] e_r, e_n;
    e_busy = (m_phase != M_IDLE);
    e_r = (m_phase == M_DRAIN && m_rd < m_acc / 4) ? m_mem_r[m_rd] : 32'h0;
    e_n = (m_phase == M_DRAIN && m_rd < m_acc / 4) ? m_mem_n[m_rd] : 32'h0;
    check("in_ready",     32'(r_in_ready),  32'(m_phase == M_FILL));
    check("dma_start",    32'(r_start),     32'(m_start));
    check("num_trans",    32'(r_num_trans), e_busy ? m_nw : 32'h0);
    check("start_addr",   r_addr,           e_busy ? m_base : 32'h0);
    check("indata_relu",  r_indata,         e_r);
    check("busy",         32'(r_busy),      32'(e_busy));
    check("done",         32'(r_done),      32'(m_done));
    check("cfg_err",      32'(r_err),       32'(m_err));
    check("underflow",    32'(r_uf),        32'(m_uf));
    check("nr_in_ready",  32'(n_in_ready),  32'(m_phase == M_FILL));
    check("nr_dma_start", 32'(n_start),     32'(m_start));
    check("nr_num_trans", 32'(n_num_trans), e_busy ? m_nw : 32'h0);
    check("nr_addr",      n_addr,           e_busy ? m_base : 32'h0);
    check("indata_norelu", n_indata,        e_n);
    check("nr_busy",      32'(n_busy),      32'(e_busy));
    check("nr_done",      32'(n_done),      32'(m_done));
    check("nr_cfg_err",   32'(n_err),       32'(m_err));
    check("nr_underflow", 32'(n_uf),        32'(m_uf));
  end

  // -------------------------------------------------------------------------
  // Stimulus (driven 1 time unit after the rising edge)
  // -------------------------------------------------------------------------
  logic [31:0] elems [$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input int nw, input logic [31:0] base, input int sh);
    cfg_num_words = OBT'(nw); cfg_base_addr = base; cfg_shift = 5'(sh);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  // Offers every element of elems; 'cont' holds in_valid high, otherwise
  // random gaps and ignored cfg_start noise are mixed in.
  task automatic feed(input bit cont);
    int idx = 0;
    int cyc = 0;
    while (idx < elems.size()) begin
      bit acc;
      in_valid      = cont || ($urandom_range(0, 3) != 0);
      in_data       = elems[idx];
      cfg_start     = !cont && ($urandom_range(0, 15) == 0);
      cfg_num_words = OBT'($urandom_range(0, 2000));
      acc = in_valid && r_in_ready;
      step();
      if (acc) idx++;
      cyc++;
      if (cyc > 8 * elems.size() + 100) begin timeout("feed"); break; end
    end
    in_valid = 1'b0; cfg_start = 1'b0;
  endtask

  task automatic wait_start();
    int c = 0;
    while (!r_start && c < 50) begin step(); c++; end
    if (!r_start) timeout("wait_dma_start");
    step();  // now in DRAIN
  endtask

  task automatic drain(input int npops, input bit gaps);
    for (int i = 0; i < npops; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) step();
      dma_indata_req = 1'b1;
      step();
      dma_indata_req = 1'b0;
    end
    step();
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; cfg_start = 1'b0; cfg_num_words = '0; cfg_base_addr = '0;
    cfg_shift = '0; in_valid = 1'b0; in_data = '0; dma_indata_req = 1'b0; dma_done = 1'b0;
    repeat (3) step();
    check("reset_busy", 32'(r_busy), 32'h0);
    check("reset_indata", r_indata, 32'h0);
    rstn = 1'b1;
    step();

    // Two-word tile of small positives.
    cfg(2, 32'h1000_0000, 0);
    elems = '{1, 2, 3, 4, 5, 6, 7, 8};
    feed(1'b0);
    wait_start();
    check("lit_t1_w0", m_mem_r[0], 32'h0403_0201);
    check("lit_t1_w1", m_mem_r[1], 32'h0807_0605);
    check("lit_t1_head", r_indata, 32'h0403_0201);
    drain(2, 1'b1);
    check("lit_t1_done", 32'(r_done), 32'h1);

    // Shift 4: 256 -> 127, -256 -> 0 (ReLU) / -128, 0x7FFF -> 127, 3.
    cfg(1, 32'h2000_0040, 4);
    elems = '{32'h0000_1000, 32'hFFFF_F000, 32'h0007_FFF0, 32'h0000_0030};
    feed(1'b0);
    wait_start();
    check("lit_t2_relu", m_mem_r[0], 32'h037F_007F);
    check("lit_t2_norelu", m_mem_n[0], 32'h037F_807F);
    drain(1, 1'b0);

    // Saturation without shift: -200, -5, 127, 300.
    cfg(1, 32'h0, 0);
    elems = '{-32'sd200, -32'sd5, 32'sd127, 32'sd300};
    feed(1'b0);
    wait_start();
    check("lit_t3_norelu", m_mem_n[0], 32'h7F7F_FB80);
    check("lit_t3_relu", m_mem_r[0], 32'h7F7F_0000);
    drain(1, 1'b0);

    // Full-depth tile with continuous input.
    cfg(DEPTH, 32'hABCD_0000, 7);
    elems.delete();
    for (int i = 0; i < 4 * DEPTH; i++) elems.push_back($urandom());
    feed(1'b1);
    check("full_in_ready_low", 32'(r_in_ready), 32'h0);
    wait_start();
    drain(DEPTH, 1'b0);

    // Illegal and empty tiles.
    cfg(DEPTH + 1, 32'h0, 0);
    check("lit_cfg_err", 32'(r_err), 32'h1);
    check("lit_err_busy", 32'(r_busy), 32'h0);
    cfg(0, 32'h0, 0);
    check("lit_empty_done", 32'(r_done), 32'h1);

    // Underflow: one word, two pops.
    cfg(1, 32'h300, 0);
    elems = '{9, 10, 11, 12};
    feed(1'b0);
    wait_start();
    drain(2, 1'b0);
    check("lit_uf_set", 32'(r_uf), 32'h1);
    cfg(1, 32'h400, 1);
    check("lit_uf_clear", 32'(r_uf), 32'h0);
    elems = '{100, 200, 300, 400};
    feed(1'b0);
    wait_start();
    drain(1, 1'b1);

    // Reset after 5 elements of a 3-word tile, then a clean 1-word tile.
    cfg(3, 32'h500, 0);
    elems = '{1, 2, 3, 4, 5};
    feed(1'b0);
    rstn = 1'b0;
    repeat (2) step();
    check("lit_abort_busy", 32'(r_busy), 32'h0);
    rstn = 1'b1;
    step();
    cfg(1, 32'h600, 0);
    elems = '{32'h11, 32'h22, 32'h33, 32'h44};
    feed(1'b0);
    wait_start();
    check("lit_after_abort", r_indata, 32'h4433_2211);
    drain(1, 1'b0);

    // Random tiles.
    for (int t = 0; t < 8; t++) begin
      int nw = $urandom_range(1, 6);
      cfg(nw, $urandom(), $urandom_range(0, 31));
      elems.delete();
      for (int i = 0; i < 4 * nw; i++) begin
        case ($urandom_range(0, 3))
          0:       elems.push_back($urandom());
          1:       elems.push_back(32'($signed($urandom_range(0, 600)) - 300));
          2:       elems.push_back($urandom_range(0, 32'h7FFF_FFFF));
          default: elems.push_back(32'h8000_0000 | $urandom());
        endcase
      end
      feed(1'b0);
      wait_start();
      drain(nw + (($urandom_range(0, 3) == 0) ? 1 : 0), 1'b1);
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
